// File: rtl/regfile_pkg.sv
// Shared widths, constants and types for the register-file write-port controller.
package regfile_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned N_INIT   = 31;
  localparam int unsigned ZERO_REG = 31;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] INIT_LAST = ADDR_W'(N_INIT - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } wr_state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wr_ctrl_if.sv
// Writeback requesters plus the regfile write port, as seen by the write controller.
interface regfile_wr_ctrl_if;
  import regfile_pkg::*;

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;

  // Requester/regfile side.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  we3, wa3, wd3
  );

  // Controller side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output we3, wa3, wd3
  );

endinterface

// File: rtl/regfile_wr_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Regfile write-port owner: fills X0..X30 with their index, then round-robins
// the port between the ALU (req0) and load (req1) writeback requesters.
module regfile_wr_ctrl
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             init_start,
  output logic             init_done,
  regfile_wr_ctrl_if.slave wr
);

  wr_state_t         state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              rr_last_q;

  wr_req_t           req0, req1;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign req0.valid = wr.req0_valid;
  assign req0.addr  = wr.req0_addr;
  assign req0.data  = wr.req0_data;
  assign req1.valid = wr.req1_valid;
  assign req1.addr  = wr.req1_addr;
  assign req1.data  = wr.req1_data;

  rr_arb2 u_arb (
    .req_i   ({req1.valid, req0.valid}),
    .last_i  (rr_last_q),
    .grant_o (grant)
  );

  assign sel_addr = grant[1] ? req1.addr : req0.addr;
  assign sel_data = grant[1] ? req1.data : req0.data;

  // Write port and handshake drive; everything held low while reset is asserted.
  always_comb begin
    init_done     = 1'b0;
    wr.req0_ready = 1'b0;
    wr.req1_ready = 1'b0;
    wr.we3        = 1'b0;
    wr.wa3        = '0;
    wr.wd3        = '0;
    if (!reset) begin
      if (state_q == INIT) begin
        wr.we3 = 1'b1;
        wr.wa3 = cnt_q;
        wr.wd3 = DATA_W'(cnt_q);
      end else begin
        init_done = 1'b1;
        if (!init_start && (grant != 2'b00)) begin
          wr.req0_ready = grant[0];
          wr.req1_ready = grant[1];
          wr.wa3        = sel_addr;
          wr.wd3        = sel_data;
          wr.we3        = (sel_addr != ZERO_ADDR);
        end
      end
    end
  end

  // rr_last resets to 1 so req0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      rr_last_q <= 1'b1;
    end else begin
      unique case (state_q)
        INIT: begin
          if (cnt_q == INIT_LAST) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        RUN: begin
          if (init_start) begin
            state_q <= INIT;
            cnt_q   <= '0;
          end else if (grant != 2'b00) begin
            rr_last_q <= grant[1];
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Scoreboard bench for regfile_wr_ctrl with a behavioural 32 x 64 regfile on its write port.
module tb_regfile_wr_ctrl;

  typedef struct packed {
    logic [1:0]  rdy;   // {req1_ready, req0_ready}
    logic        we;
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  logic clk;
  logic reset;
  logic init_start;
  logic init_done;

  int total = 0;
  int bad   = 0;
  exp_t q[$];
  logic [63:0] rf [32];

  regfile_wr_ctrl_if wr_if ();

  regfile_wr_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .init_start (init_start),
    .init_done  (init_done),
    .wr         (wr_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model; X31 reads as zero.
  always_ff @(posedge clk) begin
    if (wr_if.we3) rf[wr_if.wa3] <= wr_if.wd3;
  end

  function automatic logic [63:0] rd(input int a);
    return (a == 31) ? 64'h0 : rf[a];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] rdy, input logic we, input int a, input logic [63:0] d);
    exp_t e;
    e.rdy = rdy; e.we = we; e.addr = 5'(a); e.data = d;
    q.push_back(e);
  endtask

  task automatic push_init(input int n);
    for (int i = 0; i < n; i++) push(2'b00, 1'b1, i, 64'(i));
  endtask

  // Counts INIT cycles (init_done low) until init_done rises, bounded.
  task automatic count_init(input string name);
    int n;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (init_done) break;
      n++;
    end
    check(name, 64'(n), 64'd31);
  endtask

  // Monitor: every write-port or handshake event is popped against the scoreboard.
  initial begin
    exp_t act, e;
    forever begin
      @(negedge clk);
      if (!reset && (wr_if.we3 || wr_if.req0_ready || wr_if.req1_ready)) begin
        act.rdy  = {wr_if.req1_ready, wr_if.req0_ready};
        act.we   = wr_if.we3;
        act.addr = wr_if.wa3;
        act.data = wr_if.wd3;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected act=%h exp=<none>", act);
        end else begin
          e = q.pop_front();
          if (act !== e) begin
            bad++;
            $display("FAIL sb_event act=%h exp=%h", act, e);
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] a_dat [2];
    logic [63:0] b_dat [2];
    int ia, ib;
    logic r0, r1;

    reset = 1'b1; init_start = 1'b0;
    wr_if.req0_valid = 1'b0; wr_if.req0_addr = '0; wr_if.req0_data = '0;
    wr_if.req1_valid = 1'b0; wr_if.req1_addr = '0; wr_if.req1_data = '0;

    // Reset: everything forced low.
    @(negedge clk);
    check("rst_we3", 64'(wr_if.we3), 64'd0);
    check("rst_ready", 64'({wr_if.req1_ready, wr_if.req0_ready}), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_wa3_wd3", 64'(wr_if.wa3) | wr_if.wd3, 64'd0);
    push_init(31);
    @(posedge clk); #1 reset = 1'b0;
    count_init("init_len_after_reset");
    check("rd_x17", rd(17), 64'd17);

    // Single requester 0 write.
    push(2'b01, 1'b1, 5, 64'hDEAD_BEEF);
    @(posedge clk); #1;
    wr_if.req0_valid = 1'b1; wr_if.req0_addr = 5'd5; wr_if.req0_data = 64'hDEAD_BEEF;
    @(posedge clk); #1 wr_if.req0_valid = 1'b0;
    check("rd_x5_deadbeef", rd(5), 64'hDEAD_BEEF);

    // Both valid: last grant was req0, so req1 leads and grants alternate.
    a_dat[0] = 64'hA0; a_dat[1] = 64'hA1;
    b_dat[0] = 64'hB0; b_dat[1] = 64'hB1;
    push(2'b10, 1'b1, 4, b_dat[0]);
    push(2'b01, 1'b1, 3, a_dat[0]);
    push(2'b10, 1'b1, 4, b_dat[1]);
    push(2'b01, 1'b1, 3, a_dat[1]);
    ia = 0; ib = 0;
    wr_if.req0_valid = 1'b1; wr_if.req0_addr = 5'd3; wr_if.req0_data = a_dat[0];
    wr_if.req1_valid = 1'b1; wr_if.req1_addr = 5'd4; wr_if.req1_data = b_dat[0];
    for (int k = 0; k < 10 && (ia < 2 || ib < 2); k++) begin
      @(negedge clk);
      r0 = wr_if.req0_ready; r1 = wr_if.req1_ready;
      @(posedge clk); #1;
      if (r0) ia++;
      if (r1) ib++;
      wr_if.req0_valid = (ia < 2); wr_if.req0_data = a_dat[ia % 2];
      wr_if.req1_valid = (ib < 2); wr_if.req1_data = b_dat[ib % 2];
    end
    check("both_done", 64'(ia + ib), 64'd4);
    check("rd_x3", rd(3), 64'hA1);
    check("rd_x4", rd(4), 64'hB1);

    // XZR write: acknowledged, not written.
    push(2'b10, 1'b0, 31, 64'h1234);
    wr_if.req1_valid = 1'b1; wr_if.req1_addr = 5'd31; wr_if.req1_data = 64'h1234;
    @(posedge clk); #1 wr_if.req1_valid = 1'b0;
    check("rd_x31", rd(31), 64'd0);

    // init_start beats a pending req0, which is then served after INIT.
    push_init(31);
    push(2'b01, 1'b1, 7, 64'h77);
    wr_if.req0_valid = 1'b1; wr_if.req0_addr = 5'd7; wr_if.req0_data = 64'h77;
    init_start = 1'b1;
    @(negedge clk);
    check("istart_ready0", 64'(wr_if.req0_ready), 64'd0);
    check("istart_we3", 64'(wr_if.we3), 64'd0);
    @(posedge clk); #1 init_start = 1'b0;
    count_init("init_len_after_start");
    @(posedge clk); #1 wr_if.req0_valid = 1'b0;
    check("rd_x5_reinit", rd(5), 64'd5);
    check("rd_x7_after", rd(7), 64'h77);

    // Reset at cnt=12 restarts the full sequence from X0.
    push_init(12);
    push_init(31);
    init_start = 1'b1;
    @(posedge clk); #1 init_start = 1'b0;
    repeat (12) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid_rst_we3", 64'(wr_if.we3), 64'd0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    count_init("init_len_after_mid_reset");
    @(negedge clk);
    check("rd_x17_final", rd(17), 64'd17);
    check("sb_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
